// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution input router.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KERNEL,
    SETUP,
    STREAM,
    DRAIN
  } conv_state_e;

  localparam logic ID_KERNEL = 1'b0;
  localparam logic ID_DATA   = 1'b1;

endpackage

// File: rtl/conv_setup_timer.sv
// Post-kernel settle countdown: load to CYCLES, count down while enabled, flag the final cycle.
module conv_setup_timer #(
  parameter int CYCLES = 32
) (
  input  logic clk,
  input  logic rstn,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  localparam int TW = $clog2(CYCLES + 1);

  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (load_i) begin
      timer_d = TW'(CYCLES);
    end else if (dec_i && (timer_q != '0)) begin
      timer_d = timer_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) timer_q <= '0;
    else       timer_q <= timer_d;
  end

  // The edge that takes the timer from 1 to 0 is the edge that leaves SETUP.
  assign done_o = (timer_q == TW'(1));

endmodule

// File: rtl/conv_input_router.sv
// Routes kernel and data packets to LANES multiplier lanes with zero-latency broadcast,
// enforcing kernel length and a settle window before data is allowed through.
module conv_input_router
  import conv_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int LANES        = 2,
  parameter int KERNEL_SIZE  = 9,
  parameter int SETUP_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_id,
  input  logic [2*WIDTH-1:0] s_data,
  input  logic               s_last,
  output logic [LANES-1:0]   m_valid,
  input  logic [LANES-1:0]   m_ready,
  output logic [2*WIDTH-1:0] m_data,
  output logic               m_last,
  output logic               m_kernel,
  output logic               err_short,
  output logic               err_long,
  output logic               err_nokern
);

  localparam int CW = $clog2(KERNEL_SIZE + 1);

  conv_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, kbeat;
  logic          kern_ok_q, kern_ok_d;
  logic          err_short_q, err_short_d;
  logic          err_long_q, err_long_d;
  logic          err_nokern_q, err_nokern_d;
  logic          fwd, kern_beat, last_o, xfer, timer_load, timer_done;

  assign s_ready = rstn && (state_q != SETUP) && (&m_ready);
  assign xfer    = s_valid && s_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    kern_ok_d    = kern_ok_q;
    err_short_d  = 1'b0;
    err_long_d   = 1'b0;
    err_nokern_d = 1'b0;
    fwd          = 1'b0;
    kern_beat    = 1'b0;
    timer_load   = 1'b0;
    kbeat        = (state_q == IDLE) ? CW'(1) : cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (s_id == ID_KERNEL) begin
          fwd       = 1'b1;
          kern_beat = 1'b1;
        end else begin
          fwd = kern_ok_q;
        end
      end
      KERNEL: begin
        fwd       = 1'b1;
        kern_beat = 1'b1;
      end
      STREAM:  fwd = 1'b1;
      default: fwd = 1'b0;
    endcase

    // A kernel beat that reaches KERNEL_SIZE always closes the packet downstream.
    last_o = s_last || (kern_beat && (kbeat == CW'(KERNEL_SIZE)));

    if (xfer) begin
      case (state_q)
        IDLE, KERNEL: begin
          if (kern_beat) begin
            kern_ok_d = 1'b0;
            cnt_d     = kbeat;
            if (s_last) begin
              cnt_d = '0;
              if (kbeat == CW'(KERNEL_SIZE)) begin
                kern_ok_d  = 1'b1;
                timer_load = 1'b1;
                state_d    = SETUP;
              end else begin
                err_short_d = 1'b1;
                state_d     = IDLE;
              end
            end else if (kbeat == CW'(KERNEL_SIZE)) begin
              cnt_d      = '0;
              err_long_d = 1'b1;
              state_d    = DRAIN;
            end else begin
              state_d = KERNEL;
            end
          end else if (kern_ok_q) begin
            state_d = s_last ? IDLE : STREAM;
          end else begin
            err_nokern_d = 1'b1;
            state_d      = s_last ? IDLE : DRAIN;
          end
        end
        STREAM, DRAIN: if (s_last) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end

    if ((state_q == SETUP) && timer_done) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      kern_ok_q    <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      err_nokern_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      kern_ok_q    <= kern_ok_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
      err_nokern_q <= err_nokern_d;
    end
  end

  conv_setup_timer #(
    .CYCLES (SETUP_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (timer_load),
    .dec_i  (state_q == SETUP),
    .done_o (timer_done)
  );

  assign m_valid    = {LANES{rstn && s_valid && fwd}};
  assign m_data     = s_data;
  assign m_last     = fwd && last_o;
  assign m_kernel   = kern_beat;
  assign err_short  = err_short_q;
  assign err_long   = err_long_q;
  assign err_nokern = err_nokern_q;

endmodule
